// File: rtl/heap_level_ram.sv
// heap_level_ram: dual-port word store for one level of a hardware heap.
// Both ports may read or write every cycle. Every accepted access returns
// data. A built-in clear sequence fills the store with INIT_VALUE after
// reset or on request, and holds off port accesses while it runs.
module heap_level_ram #(
   parameter int                    DATA_WIDTH = 32,
   parameter int                    ADDR_WIDTH = 5,
   parameter int                    LEVEL      = 1,
   parameter int                    OUT_REG    = 0,
   parameter int                    RDW_MODE   = 0,
   parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clear,
   output logic                  busy,
   input  logic                  en_a,
   input  logic                  we_a,
   input  logic [ADDR_WIDTH-1:0] addr_a,
   input  logic [DATA_WIDTH-1:0] data_a,
   output logic [DATA_WIDTH-1:0] q_a,
   output logic                  valid_a,
   input  logic                  en_b,
   input  logic                  we_b,
   input  logic [ADDR_WIDTH-1:0] addr_b,
   input  logic [DATA_WIDTH-1:0] data_b,
   output logic [DATA_WIDTH-1:0] q_b,
   output logic                  valid_b,
   output logic                  collision
);

   // Handshake: a port access is taken on a rising edge when en_x=1 and
   // busy=0; it is answered exactly once by valid_x=1 for one cycle after
   // the read latency, and q_x keeps its value while valid_x=0.

   localparam int                    DEPTH     = 1 << LEVEL;
   localparam int                    IW        = (LEVEL > 0) ? LEVEL : 1;
   // Masking keeps only the level's address bits; for LEVEL=0 it forces 0.
   localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = ADDR_WIDTH'(DEPTH - 1);
   localparam logic [IW-1:0]         CNT_LAST  = IW'(DEPTH - 1);

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_CLEAR = 1'b1
   } state_t;

   state_t                state_q, state_d;
   logic [IW-1:0]         cnt_q, cnt_d;
   logic                  clr_we;

   logic [IW-1:0]         idx_a, idx_b;
   logic                  acc_a, acc_b;
   logic                  wr_a, wr_b;
   logic                  same_idx;

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [DATA_WIDTH-1:0] mem_d [DEPTH];
   logic [DATA_WIDTH-1:0] rd_a, rd_b;

   logic                  v1_a_q, v1_a_d, v1_b_q, v1_b_d;
   logic [DATA_WIDTH-1:0] d1_a_q, d1_a_d, d1_b_q, d1_b_d;
   logic                  collision_q, collision_d;

   // Clear FSM state register; reset drops straight into a clear pass
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_CLEAR;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Clear FSM next state: walk cnt over every word once, ignore clear while busy
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (clear) begin
               state_d = ST_CLEAR;
               cnt_d   = '0;
            end
         end
         ST_CLEAR: begin
            if (cnt_q == CNT_LAST) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = ST_CLEAR;
            cnt_d   = '0;
         end
      endcase
   end

   // Clear FSM outputs: busy and the clear write strobe track the CLEAR state
   always_comb begin
      busy   = (state_q == ST_CLEAR);
      clr_we = (state_q == ST_CLEAR);
   end

   // Port acceptance, write qualification and same-address detection
   always_comb begin
      idx_a    = IW'(addr_a & ADDR_MASK);
      idx_b    = IW'(addr_b & ADDR_MASK);
      acc_a    = en_a & ~busy;
      acc_b    = en_b & ~busy;
      wr_a     = acc_a & we_a;
      same_idx = (idx_a == idx_b);
      // Port A wins a same-address write; B's write is dropped.
      wr_b     = acc_b & we_b & ~(wr_a & same_idx);
   end

   // Memory next contents after this cycle's clear or port writes
   always_comb begin
      mem_d = mem_q;
      if (clr_we) begin
         mem_d[cnt_q] = INIT_VALUE;
      end
      if (wr_b) begin
         mem_d[idx_b] = data_b;
      end
      if (wr_a) begin
         mem_d[idx_a] = data_a;
      end
   end

   // Storage array; contents are defined by the clear sequence, not by reset
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   // Read data selection: pre-write contents or post-write contents
   always_comb begin
      if (RDW_MODE != 0) begin
         rd_a = mem_d[idx_a];
         rd_b = mem_d[idx_b];
      end else begin
         rd_a = mem_q[idx_a];
         rd_b = mem_q[idx_b];
      end
   end

   // First read stage next values; data registers only load on an accepted access
   always_comb begin
      v1_a_d      = acc_a;
      v1_b_d      = acc_b;
      d1_a_d      = acc_a ? rd_a : d1_a_q;
      d1_b_d      = acc_b ? rd_b : d1_b_q;
      collision_d = acc_a & acc_b & we_a & we_b & same_idx;
   end

   // First read stage and collision flag registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1_a_q      <= 1'b0;
         v1_b_q      <= 1'b0;
         d1_a_q      <= '0;
         d1_b_q      <= '0;
         collision_q <= 1'b0;
      end else begin
         v1_a_q      <= v1_a_d;
         v1_b_q      <= v1_b_d;
         d1_a_q      <= d1_a_d;
         d1_b_q      <= d1_b_d;
         collision_q <= collision_d;
      end
   end

   assign collision = collision_q;

   if (OUT_REG != 0) begin : g_out_reg
      logic                  v2_a_q, v2_a_d, v2_b_q, v2_b_d;
      logic [DATA_WIDTH-1:0] d2_a_q, d2_a_d, d2_b_q, d2_b_d;

      // Second stage next values; keeps draining regardless of busy
      always_comb begin
         v2_a_d = v1_a_q;
         v2_b_d = v1_b_q;
         d2_a_d = v1_a_q ? d1_a_q : d2_a_q;
         d2_b_d = v1_b_q ? d1_b_q : d2_b_q;
      end

      // Second stage registers
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            v2_a_q <= 1'b0;
            v2_b_q <= 1'b0;
            d2_a_q <= '0;
            d2_b_q <= '0;
         end else begin
            v2_a_q <= v2_a_d;
            v2_b_q <= v2_b_d;
            d2_a_q <= d2_a_d;
            d2_b_q <= d2_b_d;
         end
      end

      assign q_a     = d2_a_q;
      assign q_b     = d2_b_q;
      assign valid_a = v2_a_q;
      assign valid_b = v2_b_q;
   end else begin : g_no_out_reg
      assign q_a     = d1_a_q;
      assign q_b     = d1_b_q;
      assign valid_a = v1_a_q;
      assign valid_b = v1_b_q;
   end

endmodule
